front_panel_dma: RTL and testbench

FRONT_PANEL_DMA -- requirements
Module: front_panel_dma

---
 rtl/front_panel_dma.sv | 226 ++++++++++++++++++++++
 tb/tb_front_panel_dma.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/front_panel_dma.sv
// ---------------------------------------------------------------------------
// front_panel_dma
//
// Front-panel examine/deposit engine. Single-cycle command pulses from the
// panel switches are turned into a hold-request bus transaction against the
// CPU memory bus: examine reads a location, deposit writes data_sw (unless
// the target page is write-protected) and then reads it back so data_led
// always shows what memory holds. Protect/unprotect commands toggle a
// per-page flag vector that the CPU write path also consumes.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   cmd_*                 one-cycle command pulses (exam, exam_next, dep,
//                         dep_next, prot, unprot)
//   run_sw                CPU running; every command is ignored while high
//   addr_sw, data_sw      address / data switches
//   hold_req, hlda        bus request to CPU and its acknowledge
//   mem_addr, mem_wdata   panel-driven address / write data
//   mem_we, mem_rd        one-cycle write / read strobes
//   mem_rdata             read data, valid MEM_LAT cycles after mem_rd
//   addr_led, data_led    current panel address, last data read
//   prot_led              protect flag of the current page
//   busy                  a sequence is in progress
//   err_tmo               sticky hold-acknowledge timeout flag
//   prot_mask             per-page protect flags
//   state_dbg             current sequencer state (debug visibility)
//
// Bus handshake: hold_req is high from REQ through the end of the data
// phase (WR/RD/RWAIT). The bus belongs to the panel only while hlda is
// high; both strobes are gated by hlda, and losing hlda mid-sequence aborts
// to REL. In REL hold_req is low and the panel waits for hlda to fall
// before it accepts another command.
// ---------------------------------------------------------------------------
module front_panel_dma #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int PAGE_W   = 8,
  parameter int MEM_LAT  = 1,
  parameter int HOLD_TMO = 1023
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_exam,
  input  logic                     cmd_exam_next,
  input  logic                     cmd_dep,
  input  logic                     cmd_dep_next,
  input  logic                     cmd_prot,
  input  logic                     cmd_unprot,
  input  logic                     run_sw,
  input  logic [ADDR_W-1:0]        addr_sw,
  input  logic [DATA_W-1:0]        data_sw,
  output logic                     hold_req,
  input  logic                     hlda,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_we,
  output logic                     mem_rd,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [ADDR_W-1:0]        addr_led,
  output logic [DATA_W-1:0]        data_led,
  output logic                     prot_led,
  output logic                     busy,
  output logic                     err_tmo,
  output logic [(1<<PAGE_W)-1:0]   prot_mask,
  output logic [2:0]               state_dbg
);

  localparam int NUM_PAGES = 1 << PAGE_W;
  // Timeout counter only has to reach HOLD_TMO-1.
  localparam int TMO_W = (HOLD_TMO > 1) ? $clog2(HOLD_TMO) : 1;
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(HOLD_TMO - 1);
  localparam logic [1:0]        LAT_LAST = 2'(MEM_LAT - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_RD    = 3'd2;
  localparam logic [2:0] ST_RWAIT = 3'd3;
  localparam logic [2:0] ST_WR    = 3'd4;
  localparam logic [2:0] ST_REL   = 3'd5;

  logic [2:0]           state_q, state_d;
  logic [ADDR_W-1:0]    cur_addr_q, cur_addr_d;
  logic [DATA_W-1:0]    data_led_q, data_led_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [NUM_PAGES-1:0] prot_mask_q, prot_mask_d;
  logic                 err_q, err_d;
  logic                 op_wr_q, op_wr_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [1:0]           lat_cnt_q, lat_cnt_d;

  logic [PAGE_W-1:0]    cur_page;
  logic                 page_prot;

  assign cur_page  = cur_addr_q[ADDR_W-1 -: PAGE_W];
  assign page_prot = prot_mask_q[cur_page];

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    data_led_d  = data_led_q;
    wdata_d     = wdata_q;
    prot_mask_d = prot_mask_q;
    err_d       = err_q;
    op_wr_d     = op_wr_q;
    tmo_cnt_d   = tmo_cnt_q;
    lat_cnt_d   = lat_cnt_q;

    case (state_q)
      ST_IDLE: begin
        tmo_cnt_d = '0;
        // Priority chain: only the highest pending command executes.
        if (!run_sw) begin
          if (cmd_exam) begin
            cur_addr_d = addr_sw;
            op_wr_d    = 1'b0;
            err_d      = 1'b0;
            state_d    = ST_REQ;
          end else if (cmd_exam_next) begin
            cur_addr_d = cur_addr_q + ADDR_ONE;
            op_wr_d    = 1'b0;
            err_d      = 1'b0;
            state_d    = ST_REQ;
          end else if (cmd_dep) begin
            wdata_d    = data_sw;
            op_wr_d    = 1'b1;
            err_d      = 1'b0;
            state_d    = ST_REQ;
          end else if (cmd_dep_next) begin
            cur_addr_d = cur_addr_q + ADDR_ONE;
            wdata_d    = data_sw;
            op_wr_d    = 1'b1;
            err_d      = 1'b0;
            state_d    = ST_REQ;
          end else if (cmd_prot) begin
            prot_mask_d[cur_page] = 1'b1;
            err_d                 = 1'b0;
          end else if (cmd_unprot) begin
            prot_mask_d[cur_page] = 1'b0;
            err_d                 = 1'b0;
          end
        end
      end

      ST_REQ: begin
        if (hlda) begin
          tmo_cnt_d = '0;
          state_d   = op_wr_q ? ST_WR : ST_RD;
        end else if (tmo_cnt_q == TMO_LAST) begin
          // CPU never granted the bus: give up without touching memory.
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end

      ST_WR: begin
        // The write strobe itself is suppressed for protected pages; the
        // readback still runs so the LEDs show the unchanged contents.
        state_d = hlda ? ST_RD : ST_REL;
      end

      ST_RD: begin
        lat_cnt_d = '0;
        state_d   = hlda ? ST_RWAIT : ST_REL;
      end

      ST_RWAIT: begin
        if (!hlda) begin
          state_d = ST_REL;
        end else if (lat_cnt_q == LAT_LAST) begin
          data_led_d = mem_rdata;
          state_d    = ST_REL;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end

      ST_REL: begin
        if (!hlda) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cur_addr_q  <= '0;
      data_led_q  <= '0;
      wdata_q     <= '0;
      prot_mask_q <= '0;
      err_q       <= 1'b0;
      op_wr_q     <= 1'b0;
      tmo_cnt_q   <= '0;
      lat_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      data_led_q  <= data_led_d;
      wdata_q     <= wdata_d;
      prot_mask_q <= prot_mask_d;
      err_q       <= err_d;
      op_wr_q     <= op_wr_d;
      tmo_cnt_q   <= tmo_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
    end
  end

  assign hold_req  = (state_q == ST_REQ) || (state_q == ST_WR) ||
                     (state_q == ST_RD)  || (state_q == ST_RWAIT);
  assign mem_we    = (state_q == ST_WR) && hlda && !page_prot;
  assign mem_rd    = (state_q == ST_RD) && hlda;
  assign mem_addr  = cur_addr_q;
  assign mem_wdata = wdata_q;
  assign addr_led  = cur_addr_q;
  assign data_led  = data_led_q;
  assign prot_led  = page_prot;
  assign busy      = (state_q != ST_IDLE);
  assign err_tmo   = err_q;
  assign prot_mask = prot_mask_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_front_panel_dma.sv
// ---------------------------------------------------------------------------
// tb_front_panel_dma
//
// Bench for front_panel_dma with MEM_LAT=2 and HOLD_TMO=15. A bus process
// models the CPU hold acknowledge and a latency-accurate memory; a panel
// model (m_* variables, ref_mem, exp_q) predicts LEDs, flags and the exact
// strobe sequence for every accepted command.
// ---------------------------------------------------------------------------
module tb_front_panel_dma;
  localparam int AW  = 16;
  localparam int DW  = 8;
  localparam int PW  = 8;
  localparam int LAT = 2;
  localparam int TMO = 15;

  localparam logic [5:0] C_EXAM = 6'h01;
  localparam logic [5:0] C_EXNX = 6'h02;
  localparam logic [5:0] C_DEP  = 6'h04;
  localparam logic [5:0] C_DPNX = 6'h08;
  localparam logic [5:0] C_PROT = 6'h10;
  localparam logic [5:0] C_UNPR = 6'h20;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset;
  logic cmd_exam, cmd_exam_next, cmd_dep, cmd_dep_next, cmd_prot, cmd_unprot;
  logic run_sw;
  logic [AW-1:0] addr_sw;
  logic [DW-1:0] data_sw;
  logic hold_req, hlda;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic mem_we, mem_rd;
  logic [DW-1:0] mem_rdata;
  logic [AW-1:0] addr_led;
  logic [DW-1:0] data_led;
  logic prot_led, busy, err_tmo;
  logic [(1<<PW)-1:0] prot_mask;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  front_panel_dma #(.ADDR_W(AW), .DATA_W(DW), .PAGE_W(PW), .MEM_LAT(LAT), .HOLD_TMO(TMO)) dut (
    .clk(clk), .reset(reset),
    .cmd_exam(cmd_exam), .cmd_exam_next(cmd_exam_next), .cmd_dep(cmd_dep),
    .cmd_dep_next(cmd_dep_next), .cmd_prot(cmd_prot), .cmd_unprot(cmd_unprot),
    .run_sw(run_sw), .addr_sw(addr_sw), .data_sw(data_sw),
    .hold_req(hold_req), .hlda(hlda),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .addr_led(addr_led), .data_led(data_led),
    .prot_led(prot_led), .busy(busy), .err_tmo(err_tmo), .prot_mask(prot_mask),
    .state_dbg(state_dbg)
  );

  // ---------------- bench state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_viol   = 0;
  int n_rd     = 0;

  logic [7:0]  phys_mem [0:65535];
  logic [7:0]  ref_mem  [0:65535];
  logic [24:0] exp_q[$];
  logic [24:0] obs_q[$];

  logic [15:0]  m_addr;
  logic [7:0]   m_data;
  logic [7:0]   m_wdata;
  logic         m_err;
  logic [255:0] m_mask;

  int hlda_mode;   // 0 grant after hlda_delay, 1 never grant, 2 grant for one cycle
  int hlda_delay;
  int hcnt;
  bit pulsed;
  int rd_cnt;
  logic [7:0] rd_pend;
  bit rd_show;

  // ---------------- CPU / memory / bus monitor ----------------
  initial begin
    hlda = 1'b0; mem_rdata = 8'h00; hcnt = 0; pulsed = 0;
    rd_cnt = 0; rd_pend = 8'h00; rd_show = 0;
    forever begin
      @(negedge clk);
      // Read data is valid for exactly one cycle, MEM_LAT cycles after mem_rd.
      if (rd_show) begin mem_rdata = ~rd_pend; rd_show = 0; end
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin mem_rdata = rd_pend; rd_show = 1; end
      end
      if (!hold_req) begin
        hlda = 1'b0; hcnt = 0; pulsed = 0;
      end else if (hlda_mode == 0) begin
        if (hcnt >= hlda_delay) hlda = 1'b1; else hcnt++;
      end else if (hlda_mode == 2) begin
        if (pulsed) hlda = 1'b0;
        else if (hcnt >= hlda_delay) begin hlda = 1'b1; pulsed = 1; end
        else hcnt++;
      end else begin
        hlda = 1'b0;
      end
      #4;
      if (mem_we && mem_rd) n_viol++;
      if ((mem_we || mem_rd) && !hlda) n_viol++;
      if (mem_we) begin
        obs_q.push_back({1'b1, mem_addr, mem_wdata});
        phys_mem[mem_addr] = mem_wdata;
      end
      if (mem_rd) begin
        obs_q.push_back({1'b0, mem_addr, 8'h00});
        rd_pend = phys_mem[mem_addr];
        rd_cnt  = LAT;
        n_rd++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_cmd(input logic [5:0] mask, input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr_sw = a;
    data_sw = d;
    {cmd_unprot, cmd_prot, cmd_dep_next, cmd_dep, cmd_exam_next, cmd_exam} = mask;
    @(negedge clk);
    {cmd_unprot, cmd_prot, cmd_dep_next, cmd_dep, cmd_exam_next, cmd_exam} = 6'h00;
  endtask

  task automatic wait_idle(output bit timed_out);
    timed_out = 1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (!busy) begin timed_out = 0; break; end
    end
  endtask

  // Panel reference: what an accepted command must do, given how the CPU
  // will answer the hold request.
  task automatic model_cmd(input logic [5:0] mask, input logic [15:0] a, input logic [7:0] d);
    bit is_bus, is_wr;
    is_bus = 1; is_wr = 0;
    m_err  = 0;
    if (mask[0]) m_addr = a;
    else if (mask[1]) m_addr = m_addr + 16'd1;
    else if (mask[2]) is_wr = 1;
    else if (mask[3]) begin m_addr = m_addr + 16'd1; is_wr = 1; end
    else if (mask[4]) begin m_mask[m_addr[15:8]] = 1'b1; is_bus = 0; end
    else begin m_mask[m_addr[15:8]] = 1'b0; is_bus = 0; end
    if (is_wr) m_wdata = d;
    if (is_bus) begin
      if (hlda_mode == 1) begin
        m_err = 1;
      end else if (hlda_mode == 0) begin
        if (is_wr && !m_mask[m_addr[15:8]]) begin
          exp_q.push_back({1'b1, m_addr, d});
          ref_mem[m_addr] = d;
        end
        exp_q.push_back({1'b0, m_addr, 8'h00});
        m_data = ref_mem[m_addr];
      end
    end
  endtask

  task automatic model_reset();
    m_addr = 16'h0; m_data = 8'h0; m_wdata = 8'h0; m_err = 0; m_mask = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; run_sw = 1'b0; addr_sw = '0; data_sw = '0;
    {cmd_unprot, cmd_prot, cmd_dep_next, cmd_dep, cmd_exam_next, cmd_exam} = 6'h00;
    hlda_mode = 0; hlda_delay = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++; if (addr_led !== 16'h0000) begin n_fail++; $display("FAIL reset_addr_led got=%h exp=0000", addr_led); end
    n_checks++; if (data_led !== 8'h00) begin n_fail++; $display("FAIL reset_data_led got=%h exp=00", data_led); end
    n_checks++; if (prot_mask !== '0) begin n_fail++; $display("FAIL reset_prot_mask got=%h exp=0", prot_mask); end
    n_checks++; if ({err_tmo, busy, hold_req, mem_we, mem_rd, prot_led} !== 6'b0)
      begin n_fail++; $display("FAIL reset_flags got=%b exp=000000", {err_tmo, busy, hold_req, mem_we, mem_rd, prot_led}); end
    n_checks++; if (mem_wdata !== 8'h00) begin n_fail++; $display("FAIL reset_mem_wdata got=%h exp=00", mem_wdata); end
  endtask

  task automatic test_examine();
    bit to, mism;
    phys_mem[16'h1234] = 8'hA5; ref_mem[16'h1234] = 8'hA5;
    hlda_mode = 0; hlda_delay = 2;
    pulse_cmd(C_EXAM, 16'h1234, 8'h00);
    model_cmd(C_EXAM, 16'h1234, 8'h00);
    #1;
    n_checks++; if ({hold_req, busy} !== 2'b11) begin n_fail++; $display("FAIL exam_hold_req got=%b exp=11", {hold_req, busy}); end
    wait_idle(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL exam_idle_timeout got=busy exp=idle"); end
    n_checks++; if (data_led !== 8'hA5) begin n_fail++; $display("FAIL exam_data_led got=%h exp=a5", data_led); end
    n_checks++; if ({hold_req, busy} !== 2'b00) begin n_fail++; $display("FAIL exam_release got=%b exp=00", {hold_req, busy}); end
    mism = (obs_q.size() != exp_q.size());
    foreach (exp_q[k]) if (k < obs_q.size() && obs_q[k] !== exp_q[k]) mism = 1;
    n_checks++; if (mism) begin n_fail++; $display("FAIL exam_strobes got=%0d events exp=%0d events (single read at 1234)", obs_q.size(), exp_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_deposit_wrap();
    bit to, mism;
    hlda_mode = 0; hlda_delay = 1;
    pulse_cmd(C_EXAM, 16'hFFFF, 8'h00); model_cmd(C_EXAM, 16'hFFFF, 8'h00); wait_idle(to);
    pulse_cmd(C_DPNX, 16'h0000, 8'h3C); model_cmd(C_DPNX, 16'h0000, 8'h3C); wait_idle(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL depnx_idle_timeout got=busy exp=idle"); end
    n_checks++; if (addr_led !== 16'h0000) begin n_fail++; $display("FAIL depnx_addr_wrap got=%h exp=0000", addr_led); end
    n_checks++; if (data_led !== 8'h3C) begin n_fail++; $display("FAIL depnx_readback got=%h exp=3c", data_led); end
    mism = (obs_q.size() != exp_q.size());
    foreach (exp_q[k]) if (k < obs_q.size() && obs_q[k] !== exp_q[k]) mism = 1;
    n_checks++; if (mism) begin n_fail++; $display("FAIL depnx_strobes got=%0d events exp=%0d events", obs_q.size(), exp_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_protect();
    bit to, mism;
    hlda_mode = 0; hlda_delay = 0;
    pulse_cmd(C_EXAM, 16'h2055, 8'h00); model_cmd(C_EXAM, 16'h2055, 8'h00); wait_idle(to);
    pulse_cmd(C_PROT, 16'h0000, 8'h00); model_cmd(C_PROT, 16'h0000, 8'h00);
    #1;
    n_checks++; if ({busy, prot_led, prot_mask[8'h20]} !== 3'b011) begin n_fail++; $display("FAIL prot_set got=%b exp=011", {busy, prot_led, prot_mask[8'h20]}); end
    pulse_cmd(C_EXAM, 16'h2010, 8'h00); model_cmd(C_EXAM, 16'h2010, 8'h00); wait_idle(to);
    pulse_cmd(C_DEP, 16'h0000, 8'h77); model_cmd(C_DEP, 16'h0000, 8'h77); wait_idle(to);
    n_checks++; if (data_led !== m_data) begin n_fail++; $display("FAIL prot_dep_readback got=%h exp=%h", data_led, m_data); end
    n_checks++; if (prot_led !== 1'b1) begin n_fail++; $display("FAIL prot_led got=%b exp=1", prot_led); end
    pulse_cmd(C_UNPR, 16'h0000, 8'h00); model_cmd(C_UNPR, 16'h0000, 8'h00);
    pulse_cmd(C_DEP, 16'h0000, 8'h77); model_cmd(C_DEP, 16'h0000, 8'h77); wait_idle(to);
    n_checks++; if ({prot_led, data_led} !== {1'b0, 8'h77}) begin n_fail++; $display("FAIL unprot_dep got=%b/%h exp=0/77", prot_led, data_led); end
    mism = (obs_q.size() != exp_q.size());
    foreach (exp_q[k]) if (k < obs_q.size() && obs_q[k] !== exp_q[k]) mism = 1;
    n_checks++; if (mism) begin n_fail++; $display("FAIL prot_strobes got=%0d events exp=%0d events", obs_q.size(), exp_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_timeout();
    bit to;
    int held;
    hlda_mode = 1;
    pulse_cmd(C_EXAM, 16'h4321, 8'h00); model_cmd(C_EXAM, 16'h4321, 8'h00);
    held = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!hold_req) break;
      held++;
      @(negedge clk);
    end
    n_checks++; if (held != TMO) begin n_fail++; $display("FAIL tmo_hold_cycles got=%0d exp=%0d", held, TMO); end
    n_checks++; if ({err_tmo, busy} !== 2'b10) begin n_fail++; $display("FAIL tmo_err_idle got=%b exp=10", {err_tmo, busy}); end
    n_checks++; if ({addr_led, data_led} !== {m_addr, m_data}) begin n_fail++; $display("FAIL tmo_leds got=%h/%h exp=%h/%h", addr_led, data_led, m_addr, m_data); end
    hlda_mode = 0; hlda_delay = 1;
    pulse_cmd(C_EXAM, 16'h1234, 8'h00); model_cmd(C_EXAM, 16'h1234, 8'h00);
    #1;
    n_checks++; if (err_tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_clear got=%b exp=0", err_tmo); end
    wait_idle(to);
    n_checks++; if (data_led !== 8'hA5) begin n_fail++; $display("FAIL tmo_after_exam got=%h exp=a5", data_led); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_priority_drop();
    bit to, mism, seen;
    hlda_mode = 0; hlda_delay = 1;
    pulse_cmd(C_EXAM | C_DEP, 16'h3000, 8'h99); model_cmd(C_EXAM | C_DEP, 16'h3000, 8'h99); wait_idle(to);
    hlda_delay = 3;
    pulse_cmd(C_EXAM, 16'h3100, 8'h00); model_cmd(C_EXAM, 16'h3100, 8'h00);
    pulse_cmd(C_EXNX, 16'h0000, 8'h00);
    wait_idle(to);
    n_checks++; if (addr_led !== 16'h3100) begin n_fail++; $display("FAIL busy_drop_addr got=%h exp=3100", addr_led); end
    mism = (obs_q.size() != exp_q.size());
    foreach (exp_q[k]) if (k < obs_q.size() && obs_q[k] !== exp_q[k]) mism = 1;
    n_checks++; if (mism) begin n_fail++; $display("FAIL prio_strobes got=%0d events exp=%0d events", obs_q.size(), exp_q.size()); end
    obs_q.delete(); exp_q.delete();
    run_sw = 1'b1;
    pulse_cmd(6'h3F, 16'h7777, 8'h11);
    pulse_cmd(C_EXAM, 16'h7777, 8'h11);
    seen = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); #1; if (busy || hold_req) seen = 1; end
    n_checks++; if (seen) begin n_fail++; $display("FAIL run_sw_block got=busy exp=idle"); end
    n_checks++; if ({addr_led, prot_mask} !== {m_addr, m_mask}) begin n_fail++; $display("FAIL run_sw_state got=%h exp=%h", addr_led, m_addr); end
    n_checks++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL run_sw_strobes got=%0d exp=0", obs_q.size()); end
    run_sw = 1'b0;
    obs_q.delete();
  endtask

  task automatic test_hlda_abort();
    bit to, mism;
    hlda_mode = 2; hlda_delay = 1;
    pulse_cmd(C_EXAM, 16'h5000, 8'h00); model_cmd(C_EXAM, 16'h5000, 8'h00); wait_idle(to);
    n_checks++; if (to) begin n_fail++; $display("FAIL abort_idle_timeout got=busy exp=idle"); end
    n_checks++; if ({addr_led, data_led} !== {m_addr, m_data}) begin n_fail++; $display("FAIL abort_leds got=%h/%h exp=%h/%h", addr_led, data_led, m_addr, m_data); end
    pulse_cmd(C_DEP, 16'h0000, 8'hEE); model_cmd(C_DEP, 16'h0000, 8'hEE); wait_idle(to);
    n_checks++; if (mem_wdata !== 8'hEE) begin n_fail++; $display("FAIL abort_wdata got=%h exp=ee", mem_wdata); end
    mism = (obs_q.size() != exp_q.size());
    n_checks++; if (mism) begin n_fail++; $display("FAIL abort_strobes got=%0d events exp=%0d events", obs_q.size(), exp_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    bit to, mism;
    logic [5:0] mask;
    logic [15:0] a;
    logic [7:0] d;
    int sel;
    for (int it = 0; it < 40; it++) begin
      mask = 6'($urandom_range(1, 63));
      a = {8'h20 + 8'($urandom_range(0, 2)), 8'($urandom)};
      if ($urandom_range(0, 9) == 0) a = 16'hFFFF;
      d = 8'($urandom);
      sel = $urandom_range(0, 19);
      hlda_mode  = (sel < 15) ? 0 : (sel < 17) ? 1 : 2;
      hlda_delay = $urandom_range(0, 3);
      run_sw = ($urandom_range(0, 9) == 0);
      pulse_cmd(mask, a, d);
      if (!run_sw) model_cmd(mask, a, d);
      wait_idle(to);
      repeat (2) @(negedge clk);
      #1;
      run_sw = 1'b0;
      n_checks++; if (to) begin n_fail++; $display("FAIL rand_idle_timeout it=%0d", it); end
      n_checks++; if ({addr_led, mem_addr} !== {m_addr, m_addr}) begin n_fail++; $display("FAIL rand_addr it=%0d got=%h/%h exp=%h", it, addr_led, mem_addr, m_addr); end
      n_checks++; if (data_led !== m_data) begin n_fail++; $display("FAIL rand_data_led it=%0d got=%h exp=%h", it, data_led, m_data); end
      n_checks++; if (err_tmo !== m_err) begin n_fail++; $display("FAIL rand_err_tmo it=%0d got=%b exp=%b", it, err_tmo, m_err); end
      n_checks++; if (prot_mask !== m_mask) begin n_fail++; $display("FAIL rand_prot_mask it=%0d got=%h exp=%h", it, prot_mask, m_mask); end
      n_checks++; if (prot_led !== m_mask[m_addr[15:8]]) begin n_fail++; $display("FAIL rand_prot_led it=%0d got=%b exp=%b", it, prot_led, m_mask[m_addr[15:8]]); end
      n_checks++; if (mem_wdata !== m_wdata) begin n_fail++; $display("FAIL rand_wdata it=%0d got=%h exp=%h", it, mem_wdata, m_wdata); end
      mism = (obs_q.size() != exp_q.size());
      foreach (exp_q[k]) if (k < obs_q.size() && obs_q[k] !== exp_q[k]) mism = 1;
      n_checks++; if (mism) begin n_fail++; $display("FAIL rand_strobes it=%0d got=%0d events exp=%0d events", it, obs_q.size(), exp_q.size()); end
      obs_q.delete(); exp_q.delete();
    end
  endtask

  task automatic test_reset_in_rwait();
    bit to, found;
    int rd0;
    hlda_mode = 0; hlda_delay = 1;
    pulse_cmd(C_EXAM, 16'h6000, 8'h00); model_cmd(C_EXAM, 16'h6000, 8'h00); wait_idle(to);
    pulse_cmd(C_PROT, 16'h0000, 8'h00); model_cmd(C_PROT, 16'h0000, 8'h00);
    pulse_cmd(C_DEP, 16'h0000, 8'h42); model_cmd(C_DEP, 16'h0000, 8'h42); wait_idle(to);
    hlda_delay = 0;
    rd0 = n_rd;
    pulse_cmd(C_EXAM, 16'h6001, 8'h00);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      if (n_rd > rd0) begin found = 1; break; end
      @(negedge clk);
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL rwait_read_timeout got=no read exp=read"); end
    reset = 1'b1;
    @(negedge clk);
    #1;
    n_checks++; if ({hold_req, busy, mem_rd, mem_we, err_tmo, prot_led} !== 6'b0)
      begin n_fail++; $display("FAIL rwait_reset_flags got=%b exp=000000", {hold_req, busy, mem_rd, mem_we, err_tmo, prot_led}); end
    n_checks++; if ({addr_led, data_led, mem_wdata} !== 32'h0) begin n_fail++; $display("FAIL rwait_reset_regs got=%h/%h/%h exp=0", addr_led, data_led, mem_wdata); end
    n_checks++; if (prot_mask !== '0) begin n_fail++; $display("FAIL rwait_reset_mask got=%h exp=0", prot_mask); end
    reset = 1'b0;
    model_reset();
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_bus_rules();
    n_checks++; if (n_viol != 0) begin n_fail++; $display("FAIL strobe_rules got=%0d violations exp=0", n_viol); end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      phys_mem[i] = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
      ref_mem[i]  = 8'(i) ^ 8'(i >> 8) ^ 8'h5A;
    end
    test_reset();
    test_examine();
    test_deposit_wrap();
    test_protect();
    test_timeout();
    test_priority_drop();
    test_hlda_abort();
    test_random();
    test_reset_in_rwait();
    test_bus_rules();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
